vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator; successor to the fixed 640x480 sync block.
//  Generates pixel-rate clock enable, h/v counters, sync pulses, video_on and line/frame strobes.
//  Timing, sync polarity and clock divide ratio are set by parameters.
//  Drives the pixel/text generators downstream in the same clk domain.
// PARAMETERS
//  CNT_W     11   counter/pixel coordinate width
//  CLK_DIV   2    clk cycles per pixel (>=1)
//  H_ACTIVE  640  visible pixels per line
//  H_FRONT   16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BACK    48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines
//  V_FRONT   10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BACK    33   vertical back porch, lines
//  HSYNC_POL 0    asserted level of hsync (0 = active low)
//  VSYNC_POL 0    asserted level of vsync
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  en          in   1      run enable; low freezes all timing state
//  p_tick      out  1      pixel clock enable, 1 clk wide
//  pixel_x     out  CNT_W  current horizontal count
//  pixel_y     out  CNT_W  current vertical count
//  video_on    out  1      pixel_x<H_ACTIVE && pixel_y<V_ACTIVE
//  hsync       out  1      horizontal sync, polarity HSYNC_POL
//  vsync       out  1      vertical sync, polarity VSYNC_POL
//  line_start  out  1      1-clk strobe when pixel_x wraps to 0
//  frame_start out  1      1-clk strobe when (x,y) wraps to (0,0)
//  frame_cnt   out  16     frame counter (optional feature)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Line order: active, front porch, sync, back porch. H_TOTAL = sum of H_*, V_TOTAL = sum of V_*.
//  - Divider div_cnt 0..CLK_DIV-1 advances while en=1.
//    p_tick = en && div_cnt==CLK_DIV-1 (combinational from register). CLK_DIV=1: p_tick=en.
//  - On p_tick: h increments and wraps at H_TOTAL-1 -> 0. v increments only on h wrap and wraps at V_TOTAL-1 -> 0.
//  - hsync = HSYNC_POL for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], else ~HSYNC_POL. vsync uses the same rule on v.
//  - Outputs are registered and computed from next-count values, so all are coherent.
//    pixel_x/y, video_on, hsync and vsync change on the same clk edge as the counters, with zero skew between them.
//  - line_start and frame_start are registered and high for exactly the clk in which the new (wrapped) count is first presented.
//    frame_start implies line_start.
//  - en=0: div_cnt, counters and outputs hold. p_tick=0; strobes=0.
//    Re-enabling resumes from the held state.
//  - Reset values (reset wins over en at any point mid-frame):
//    div_cnt=0, pixel_x=pixel_y=0, video_on=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=frame_start=0, frame_cnt=0, p_tick=0.
//  - Elaboration check: H_TOTAL and V_TOTAL must fit in CNT_W bits, and CLK_DIV>=1; otherwise $error.
// CONFIGURATION
//  VGA_TIMING_FRAME_CNT_EN defined:
//    frame_cnt increments by 1 on each frame_start and wraps 65535 -> 0.
//    Held while en=0; cleared by reset.
//  Not defined: frame_cnt tied to 16'd0, and no counter logic is generated.
// STRUCTURE
//  Shared include vga_timing_defs.vh holds:
//    default 640x480@60 timing constants;
//    an 800x600 set;
//    polarity constants VGA_POL_LOW/VGA_POL_HIGH.
//  Sub-module vga_tick_div (CLK_DIV clock-enable divider with en) produces p_tick.
//  Counters, decode and strobes stay in this module.
// TESTING
//  1. reset, en=1, defaults -> p_tick every 2nd clk; pixel_x 0..799, wraps after 1600 clks; line_start once per line.
//  2. Defaults -> hsync=0 for exactly 96 p_ticks from pixel_x=656..751; vsync=0 only on pixel_y=490,491.
//  3. Full frame -> video_on high on exactly 307200 p_ticks; frame_start every 420000 p_ticks, coincident with line_start.
//  4. en=0 at pixel_x=100 for 50 clks -> counters hold at 100, p_tick=0; en=1 -> next p_tick gives pixel_x=101.
//  5. reset at (700,300) -> next clk all outputs at reset values; counting restarts from (0,0).
//  6. CLK_DIV=1, H/V=8/2/2/2 -> frame_cnt 0->1->2 at successive frame_starts with macro defined; stays 0 without it.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared VGA timing constants, polarity constants and decode helper
package vga_timing_gen_pkg;

  localparam bit VGA_POL_LOW  = 1'b0;
  localparam bit VGA_POL_HIGH = 1'b1;

  // 640x480@60, 25.175 MHz nominal pixel rate, both syncs active low
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;
  localparam bit VGA640_HPOL     = VGA_POL_LOW;
  localparam bit VGA640_VPOL     = VGA_POL_LOW;

  // 800x600@60, 40 MHz nominal pixel rate, both syncs active high
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FRONT  = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BACK   = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FRONT  = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BACK   = 23;
  localparam bit VGA800_HPOL     = VGA_POL_HIGH;
  localparam bit VGA800_VPOL     = VGA_POL_HIGH;

  function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                   input int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// rtl/vga_tick_div.sv - CLK_DIV clock-enable divider producing the pixel tick
module vga_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_tick_div: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  // With CLK_DIV=1 the counter is pinned at 0 == DIV_LAST, so the tick follows en.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign p_tick = en && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CNT_W     = 11,
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter bit HSYNC_POL = VGA640_HPOL,
  parameter bit VSYNC_POL = VGA640_VPOL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  if ((H_TOTAL >= (1 << CNT_W)) || (V_TOTAL >= (1 << CNT_W))) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic tick;

  vga_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .p_tick(tick)
  );

  assign p_tick = tick;

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_wrap, v_wrap;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end
    end
  end

  // Decode from the next counts so every output lands on the same edge as the counters.
  always_comb begin
    video_on_d    = (h_d < H_ACT_C) && (v_d < V_ACT_C);
    hsync_d       = in_span(32'(h_d), H_ACTIVE + H_FRONT, H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = in_span(32'(v_d), V_ACTIVE + V_FRONT, V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d  = tick && h_wrap;
    frame_start_d = tick && h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      video_on_q    <= 1'b1;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Advances on the edge that presents the wrapped (0,0), alongside frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a raster arithmetic model
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic en;

  logic [2:0]  pt, vo, hs, vs, ls, fs;
  logic [10:0] px [3];
  logic [10:0] py [3];
  logic [15:0] fc [3];
  logic [7:0]  px_a, py_a;
  logic [5:0]  px_c, py_c;

  int p_div [3] = '{3, 2, 1};
  int p_ha  [3] = '{20, 640, 8};
  int p_hf  [3] = '{4, 16, 2};
  int p_hs  [3] = '{6, 96, 2};
  int p_hb  [3] = '{5, 48, 2};
  int p_va  [3] = '{12, 480, 8};
  int p_vf  [3] = '{2, 10, 2};
  int p_vs  [3] = '{3, 2, 2};
  int p_vb  [3] = '{4, 33, 2};
  bit p_hpol[3] = '{1'b0, 1'b0, 1'b1};
  bit p_vpol[3] = '{1'b1, 1'b0, 1'b0};

  // model state: enabled clocks and pixel ticks since reset, plus pending strobes
  int m_clk [3];
  int m_pix [3];
  bit m_ls  [3];
  bit m_fs  [3];
  int m_fc  [3];

  int total_checks;
  int passed_checks;

  vga_timing_gen #(
    .CNT_W(8), .CLK_DIV(3),
    .H_ACTIVE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) u_a (
    .clk(clk), .reset(rst), .en(en), .p_tick(pt[0]), .pixel_x(px_a), .pixel_y(py_a),
    .video_on(vo[0]), .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]),
    .frame_start(fs[0]), .frame_cnt(fc[0])
  );

  vga_timing_gen u_b (
    .clk(clk), .reset(rst), .en(en), .p_tick(pt[1]), .pixel_x(px[1]), .pixel_y(py[1]),
    .video_on(vo[1]), .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]),
    .frame_start(fs[1]), .frame_cnt(fc[1])
  );

  vga_timing_gen #(
    .CNT_W(6), .CLK_DIV(1),
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_c (
    .clk(clk), .reset(rst), .en(en), .p_tick(pt[2]), .pixel_x(px_c), .pixel_y(py_c),
    .video_on(vo[2]), .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]),
    .frame_start(fs[2]), .frame_cnt(fc[2])
  );

  assign px[0] = 11'(px_a);
  assign py[0] = 11'(py_a);
  assign px[2] = 11'(px_c);
  assign py[2] = 11'(py_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic model_step(input bit r, input bit e);
    for (int i = 0; i < 3; i++) begin
      int ht, vt;
      bit tick;
      ht = p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
      vt = p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
      m_ls[i] = 1'b0;
      m_fs[i] = 1'b0;
      if (r) begin
        m_clk[i] = 0;
        m_pix[i] = 0;
        m_fc[i]  = 0;
      end else if (e) begin
        tick = (m_clk[i] % p_div[i]) == (p_div[i] - 1);
        m_clk[i]++;
        if (tick) begin
          m_pix[i]++;
          m_ls[i] = (m_pix[i] % ht) == 0;
          m_fs[i] = (m_pix[i] % (ht * vt)) == 0;
          if (m_fs[i]) m_fc[i] = (m_fc[i] + 1) % 65536;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int ht, vt, x, y, hlo, vlo;
      bit e_pt, e_hs, e_vs;
      ht   = p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
      vt   = p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
      x    = m_pix[i] % ht;
      y    = (m_pix[i] / ht) % vt;
      hlo  = p_ha[i] + p_hf[i];
      vlo  = p_va[i] + p_vf[i];
      e_pt = en && ((m_clk[i] % p_div[i]) == (p_div[i] - 1));
      e_hs = (x >= hlo && x < hlo + p_hs[i]) ? p_hpol[i] : !p_hpol[i];
      e_vs = (y >= vlo && y < vlo + p_vs[i]) ? p_vpol[i] : !p_vpol[i];
      chk($sformatf("u%0d.p_tick", i), pt[i], e_pt);
      chk($sformatf("u%0d.pixel_x", i), px[i], x);
      chk($sformatf("u%0d.pixel_y", i), py[i], y);
      chk($sformatf("u%0d.video_on", i), vo[i], (x < p_ha[i]) && (y < p_va[i]));
      chk($sformatf("u%0d.hsync", i), hs[i], e_hs);
      chk($sformatf("u%0d.vsync", i), vs[i], e_vs);
      chk($sformatf("u%0d.line_start", i), ls[i], m_ls[i]);
      chk($sformatf("u%0d.frame_start", i), fs[i], m_fs[i]);
      chk($sformatf("u%0d.frame_cnt", i), fc[i], FC_EN ? m_fc[i] : 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(rst, en);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pin_reset(input int upto);
    bit hs_exp [3] = '{1'b1, 1'b1, 1'b0};
    bit vs_exp [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < upto; i++) begin
      chk($sformatf("rst_u%0d.p_tick", i), pt[i], 0);
      chk($sformatf("rst_u%0d.pixel_x", i), px[i], 0);
      chk($sformatf("rst_u%0d.pixel_y", i), py[i], 0);
      chk($sformatf("rst_u%0d.video_on", i), vo[i], 1);
      chk($sformatf("rst_u%0d.hsync", i), hs[i], hs_exp[i]);
      chk($sformatf("rst_u%0d.vsync", i), vs[i], vs_exp[i]);
      chk($sformatf("rst_u%0d.line_start", i), ls[i], 0);
      chk($sformatf("rst_u%0d.frame_start", i), fs[i], 0);
      chk($sformatf("rst_u%0d.frame_cnt", i), fc[i], 0);
    end
  endtask

  initial begin
    int early_ls, hs_low, first_hs_low, vo_cnt;
    bit found;
    total_checks  = 0;
    passed_checks = 0;
    rst = 1'b1;
    en  = 1'b0;

    repeat (3) cycle();
    pin_reset(3);

    // free-running from reset: line, frame and sync boundaries at hand-computed clocks
    rst = 1'b0;
    en  = 1'b1;
    early_ls = 0; hs_low = 0; first_hs_low = -1; vo_cnt = 0;
    for (int k = 1; k <= 2300; k++) begin
      cycle();
      if (k < 1600 && ls[1]) early_ls++;
      if (k <= 1600 && !hs[1]) begin
        hs_low++;
        if (first_hs_low < 0) first_hs_low = k;
      end
      if (k <= 2205 && vo[0]) vo_cnt++;
      if (k == 1600) begin
        chk("b_line_start_at_1600", ls[1], 1);
        chk("b_x_wrap_at_1600", px[1], 0);
        chk("b_y_after_line0", py[1], 1);
      end
      if (k == 196) begin
        chk("c_frame_start_at_196", fs[2], 1);
        chk("c_line_with_frame", ls[2], 1);
        chk("c_frame_cnt_1", fc[2], FC_EN ? 1 : 0);
      end
      if (k == 392) chk("c_frame_cnt_2", fc[2], FC_EN ? 2 : 0);
      if (k == 2205) chk("a_frame_start_at_2205", fs[0], 1);
    end
    chk("b_no_early_line_start", early_ls, 0);
    chk("b_hsync_low_clks", hs_low, 192);
    chk("b_hsync_first_low_clk", first_hs_low, 1312);
    chk("a_video_on_clks_frame", vo_cnt, 720);

    // pause at pixel_x=100 for 50 clocks, then resume
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      cycle();
      if (px[1] == 100) found = 1'b1;
    end
    chk("b_reach_x100", found, 1);
    en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      chk("b_hold_x100", px[1], 100);
      chk("hold_no_tick", pt, 0);
    end
    en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      cycle();
      if (pt[1]) found = 1'b1;
    end
    chk("b_resume_tick", found, 1);
    cycle();
    chk("b_resume_x101", px[1], 101);

    // mid-frame reset with en held high
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      cycle();
      if (px[0] == 25 && py[0] == 10) found = 1'b1;
    end
    chk("a_reach_25_10", found, 1);
    rst = 1'b1;
    cycle();
    pin_reset(2);
    rst = 1'b0;
    repeat (3) cycle();
    chk("a_restart_x1", px[0], 1);
    chk("a_restart_y0", py[0], 0);

    // randomized enable with rare resets
    for (int k = 0; k < 15000; k++) begin
      en  = ($urandom_range(0, 9) < 8);
      rst = ($urandom_range(0, 1999) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
